// File: rtl/nas_vid_rx_pkg.sv
// nas_vid_rx_pkg: shared state encodings and default NASCOM 2 timing
// for the video capture receiver.
package nas_vid_rx_pkg;

  typedef enum logic [2:0] {
    S_HUNT   = 3'd0,
    S_VWAIT  = 3'd1,
    S_PORCH  = 3'd2,
    S_ACTIVE = 3'd3,
    S_LINE   = 3'd4
  } state_t;

  localparam int DEF_HSYNC_MIN    = 16;
  localparam int DEF_VSYNC_MIN    = 256;
  localparam int DEF_H_PORCH      = 96;
  localparam int DEF_V_PORCH      = 16;
  localparam int DEF_ACTIVE_CHARS = 48;
  localparam int DEF_ACTIVE_LINES = 224;
  localparam int TMO_SAMPLES      = 1024;

endpackage

// File: rtl/nas_vid_rx_if.sv
// nas_vid_rx_if: composite video input pair and captured pixel
// byte bundle between a video source/checker and the receiver.
interface nas_vid_rx_if;

  logic       vid_sync;
  logic       vid_data;
  logic [7:0] pix_byte;
  logic       pix_valid;
  logic [5:0] pix_col;
  logic [8:0] pix_line;

  modport master (
    output vid_sync,
    output vid_data,
    input  pix_byte,
    input  pix_valid,
    input  pix_col,
    input  pix_line
  );

  modport slave (
    input  vid_sync,
    input  vid_data,
    output pix_byte,
    output pix_valid,
    output pix_col,
    output pix_line
  );

endinterface

// File: rtl/nas_sync_classify.sv
// nas_sync_classify: synchronises sync/data, derives the 8MHz dot
// enable and classifies sync-low pulses as hsync or vsync.
module nas_sync_classify
  import nas_vid_rx_pkg::*;
#(
  parameter int HSYNC_MIN = DEF_HSYNC_MIN,
  parameter int VSYNC_MIN = DEF_VSYNC_MIN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sync,
  input  logic i_data,
  output logic o_dot,
  output logic o_data,
  output logic o_fall,
  output logic o_hsync,
  output logic o_vsync
);

  localparam logic [11:0] LP_HMIN = 12'(HSYNC_MIN);
  localparam logic [11:0] LP_VMIN = 12'(VSYNC_MIN);

  logic [1:0]  r_sync_ff;
  logic [1:0]  r_data_ff;
  logic        r_div;
  logic        r_prev;
  logic [11:0] r_low_cnt;
  logic        w_sync;
  logic        w_rise;

  // sync idles high so reset release never looks like an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_ff <= 2'b11;
      r_data_ff <= 2'b00;
      r_div     <= 1'b0;
    end else begin
      r_sync_ff <= {r_sync_ff[0], i_sync};
      r_data_ff <= {r_data_ff[0], i_data};
      r_div     <= ~r_div;
    end
  end

  assign w_sync = r_sync_ff[1];
  assign o_dot  = r_div;
  assign o_data = r_data_ff[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev    <= 1'b1;
      r_low_cnt <= '0;
    end else if (r_div) begin
      r_prev <= w_sync;
      if (w_sync)
        r_low_cnt <= '0;
      else if (r_low_cnt != 12'hFFF)
        r_low_cnt <= r_low_cnt + 12'd1;
    end
  end

  assign w_rise  = r_div & w_sync & ~r_prev;
  assign o_fall  = r_div & ~w_sync & r_prev;
  assign o_vsync = w_rise & (r_low_cnt >= LP_VMIN);
  assign o_hsync = w_rise & (r_low_cnt >= LP_HMIN)
                 & (r_low_cnt < LP_VMIN);

endmodule

// File: rtl/nas_vid_rx.sv
// nas_vid_rx: NASCOM 2 video capture receiver, rebuilds tagged
// 8-pixel character bytes from the composite sync/video pair.
module nas_vid_rx
  import nas_vid_rx_pkg::*;
#(
  parameter int HSYNC_MIN    = DEF_HSYNC_MIN,
  parameter int VSYNC_MIN    = DEF_VSYNC_MIN,
  parameter int H_PORCH      = DEF_H_PORCH,
  parameter int V_PORCH      = DEF_V_PORCH,
  parameter int ACTIVE_CHARS = DEF_ACTIVE_CHARS,
  parameter int ACTIVE_LINES = DEF_ACTIVE_LINES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        err_clr,
  nas_vid_rx_if.slave vif,
  output logic        frame_start,
  output logic        frame_done,
  output logic        sync_err
);

  localparam logic [7:0]  LP_VP   = 8'(V_PORCH);
  localparam logic [10:0] LP_HP   = 11'(H_PORCH - 1);
  localparam logic [5:0]  LP_LCOL = 6'(ACTIVE_CHARS - 1);
  localparam logic [8:0]  LP_LNS  = 9'(ACTIVE_LINES);
  localparam logic [10:0] LP_TMO  = 11'(TMO_SAMPLES - 1);

  logic w_dot, w_data, w_fall, w_hs, w_vs;

  nas_sync_classify #(
    .HSYNC_MIN(HSYNC_MIN),
    .VSYNC_MIN(VSYNC_MIN)
  ) u_cls (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_sync (vif.vid_sync),
    .i_data (vif.vid_data),
    .o_dot  (w_dot),
    .o_data (w_data),
    .o_fall (w_fall),
    .o_hsync(w_hs),
    .o_vsync(w_vs)
  );

  state_t      r_state, w_state;
  logic [7:0]  r_skip, w_skip;
  logic [10:0] r_cnt, w_cnt;
  logic [2:0]  r_bit, w_bit;
  logic [5:0]  r_col, w_col;
  logic [8:0]  r_line, w_line;
  logic [7:0]  r_shift, w_shift;
  logic        w_emit, w_fs, w_fd, w_err;
  logic [7:0]  r_byte;
  logic        r_valid;
  logic [5:0]  r_pcol;
  logic [8:0]  r_pline;
  logic        r_fs, r_fd, r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_HUNT;
    else        r_state <= w_state;
  end

  always_comb begin
    w_state = r_state;
    w_skip  = r_skip;
    w_cnt   = r_cnt;
    w_bit   = r_bit;
    w_col   = r_col;
    w_line  = r_line;
    w_shift = r_shift;
    w_emit  = 1'b0;
    w_fs    = 1'b0;
    w_fd    = 1'b0;
    w_err   = 1'b0;
    unique case (r_state)
      S_HUNT: ;
      S_VWAIT: if (w_dot) begin
        if (w_hs) begin
          w_skip = r_skip + 8'd1;
          w_cnt  = '0;
          if (w_skip == LP_VP) begin
            w_state = S_PORCH;
            w_cnt   = 11'd1;
          end
        end else if (r_cnt == LP_TMO) begin
          w_state = S_HUNT;
          w_err   = 1'b1;
        end else begin
          w_cnt = r_cnt + 11'd1;
        end
      end
      S_PORCH: if (w_dot) begin
        if (w_hs) begin
          w_cnt = 11'd1;
        end else if (r_cnt == LP_HP) begin
          w_state = S_ACTIVE;
          w_bit   = '0;
          w_col   = '0;
        end else begin
          w_cnt = r_cnt + 11'd1;
        end
      end
      // a sync edge mid-line drops the partial byte, line not counted
      S_ACTIVE: if (w_dot) begin
        if (w_fall) begin
          w_state = S_LINE;
          w_cnt   = '0;
          w_err   = 1'b1;
        end else begin
          w_shift = {r_shift[6:0], w_data};
          w_bit   = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
            w_emit = 1'b1;
            w_col  = r_col + 6'd1;
            if (r_col == LP_LCOL) begin
              w_state = S_LINE;
              w_line  = r_line + 9'd1;
              w_cnt   = '0;
            end
          end
        end
      end
      S_LINE: if (r_line == LP_LNS) begin
        w_state = S_HUNT;
        w_fd    = 1'b1;
      end else if (w_dot) begin
        if (w_hs) begin
          w_state = S_PORCH;
          w_cnt   = 11'd1;
        end else if (r_cnt == LP_TMO) begin
          w_state = S_HUNT;
          w_err   = 1'b1;
        end else begin
          w_cnt = r_cnt + 11'd1;
        end
      end
      default: w_state = S_HUNT;
    endcase
    if (w_vs && r_state != S_ACTIVE) begin
      w_state = S_VWAIT;
      w_fs    = 1'b1;
      w_fd    = 1'b0;
      w_err   = (r_state != S_HUNT);
      w_line  = '0;
      w_skip  = '0;
      w_cnt   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skip  <= '0;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_col   <= '0;
      r_line  <= '0;
      r_shift <= '0;
      r_byte  <= '0;
      r_valid <= 1'b0;
      r_pcol  <= '0;
      r_pline <= '0;
      r_fs    <= 1'b0;
      r_fd    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_skip  <= w_skip;
      r_cnt   <= w_cnt;
      r_bit   <= w_bit;
      r_col   <= w_col;
      r_line  <= w_line;
      r_shift <= w_shift;
      r_valid <= w_emit;
      r_fs    <= w_fs;
      r_fd    <= w_fd;
      if (w_emit) begin
        r_byte  <= w_shift;
        r_pcol  <= r_col;
        r_pline <= r_line;
      end
      if (w_err)        r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;
    end
  end

  assign vif.pix_byte  = r_byte;
  assign vif.pix_valid = r_valid;
  assign vif.pix_col   = r_pcol;
  assign vif.pix_line  = r_pline;
  assign frame_start   = r_fs;
  assign frame_done    = r_fd;
  assign sync_err      = r_err;

endmodule

// File: tb/tb_nas_vid_rx.sv
// tb_nas_vid_rx: drives composite sync/video frames into nas_vid_rx
// and scores every captured byte against a queue of expected bytes.
`timescale 1ns/1ps
module tb_nas_vid_rx;
  import nas_vid_rx_pkg::*;

  localparam int CH = 6;
  localparam int LN = 10;
  localparam int HP = 96;
  localparam int VP = 16;

  typedef struct packed {
    logic [7:0] b;
    logic [5:0] c;
    logic [8:0] l;
  } exp_t;

  typedef struct {
    int         vs_w;
    int         hs_w;
    logic [7:0] pat;
    int         exp_fs;
    bit         exp_cap;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_clr = 1'b0;
  logic frame_start, frame_done, sync_err;

  nas_vid_rx_if vif();

  nas_vid_rx #(
    .HSYNC_MIN   (16),
    .VSYNC_MIN   (256),
    .H_PORCH     (HP),
    .V_PORCH     (VP),
    .ACTIVE_CHARS(CH),
    .ACTIVE_LINES(LN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .err_clr    (err_clr),
    .vif        (vif),
    .frame_start(frame_start),
    .frame_done (frame_done),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   fs_cnt = 0;
  int   fd_cnt = 0;
  exp_t q[$];
  exp_t got, e;

  always @(negedge clk) begin
    if (frame_start) fs_cnt++;
    if (frame_done) fd_cnt++;
    if (vif.pix_valid) begin
      got = {vif.pix_byte, vif.pix_col, vif.pix_line};
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL strobe_extra got=%h/%0d/%0d req=none",
                 got.b, got.c, got.l);
      end else begin
        e = q.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL strobe got=%h/%0d/%0d req=%h/%0d/%0d",
                   got.b, got.c, got.l, e.b, e.c, e.l);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d req=%0d", nm, act, exp);
    end
  endtask

  task automatic dot(input logic s, input logic d);
    vif.vid_sync = s;
    vif.vid_data = d;
    repeat (2) @(negedge clk);
  endtask

  task automatic run(input int n, input logic s);
    for (int i = 0; i < n; i++) dot(s, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int c,
                           input int l, input bit ex);
    if (ex) q.push_back({b, 6'(c), 9'(l)});
    for (int i = 7; i >= 0; i--) dot(1'b1, b[i]);
  endtask

  task automatic porch(input bit glitch);
    for (int i = 0; i < HP; i++)
      dot(!(glitch && i >= 40 && i < 48), 1'b0);
  endtask

  task automatic line(input int l, input bit glitch);
    run(40, 1'b0);
    porch(glitch);
    for (int c = 0; c < CH; c++)
      send_byte(8'(c) ^ 8'(l), c, l, 1'b1);
    run(8, 1'b1);
  endtask

  task automatic frame(input bit vs, input int gl,
                       input int el, input int vl);
    if (vs) begin
      run(300, 1'b0);
      run(8, 1'b1);
    end
    for (int i = 0; i < VP - 1; i++) begin
      run(40, 1'b0);
      run(10, 1'b1);
    end
    for (int l = 0; l < LN; l++) begin
      if (l == vl) begin
        run(300, 1'b0);
        run(8, 1'b1);
        return;
      end
      if (l == el) begin
        run(40, 1'b0);
        porch(1'b0);
        for (int c = 0; c < 4; c++)
          send_byte(8'(c) ^ 8'(l), c, l, 1'b1);
        repeat (3) dot(1'b1, 1'b1);
      end
      line(l, l == gl);
    end
    run(8, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    vif.vid_sync = 1'b1;
    vif.vid_data = 1'b0;
    repeat (4) @(negedge clk);
    q.delete();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(nm, q.size(), 0);
  endtask

  initial begin
    vec_t tbl[5];
    int fs0, fd0;
    tbl[0] = '{300, 40, 8'hA5, 1, 1'b1};
    tbl[1] = '{256, 16, 8'h3C, 1, 1'b1};
    tbl[2] = '{255, 40, 8'h5A, 0, 1'b0};
    tbl[3] = '{300, 15, 8'hC3, 1, 1'b0};
    tbl[4] = '{400, 255, 8'h81, 1, 1'b1};

    vif.vid_sync = 1'b1;
    vif.vid_data = 1'b0;
    rst_n = 1'b0;
    fs0 = fs_cnt;
    run(300, 1'b0);
    run(20, 1'b1);
    run(300, 1'b0);
    run(20, 1'b1);
    chk("fs_in_reset", fs_cnt - fs0, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        {vif.pix_valid, vif.pix_byte, vif.pix_col, vif.pix_line,
         frame_start, frame_done, sync_err}, 0);

    foreach (tbl[i]) begin
      do_reset();
      fs0 = fs_cnt;
      run(tbl[i].vs_w, 1'b0);
      run(8, 1'b1);
      for (int k = 0; k < VP; k++) begin
        run(tbl[i].hs_w, 1'b0);
        if (k < VP - 1) run(10, 1'b1);
      end
      porch(1'b0);
      send_byte(tbl[i].pat, 0, 0, tbl[i].exp_cap);
      run(8, 1'b1);
      chk($sformatf("vec%0d_fs", i), fs_cnt - fs0, tbl[i].exp_fs);
      drain($sformatf("vec%0d_strobe", i));
      chk($sformatf("vec%0d_err", i), sync_err, 0);
    end

    do_reset();
    fs0 = fs_cnt;
    fd0 = fd_cnt;
    frame(1'b1, -1, -1, -1);
    drain("full_strobes");
    chk("full_fs", fs_cnt - fs0, 1);
    chk("full_fd", fd_cnt - fd0, 1);
    chk("full_err", sync_err, 0);

    fd0 = fd_cnt;
    frame(1'b1, 2, -1, -1);
    drain("glitch_strobes");
    chk("glitch_fd", fd_cnt - fd0, 1);
    chk("glitch_err", sync_err, 0);

    fd0 = fd_cnt;
    frame(1'b1, -1, 5, -1);
    drain("hserr_strobes");
    chk("hserr_fd", fd_cnt - fd0, 1);
    chk("hserr_err", sync_err, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    chk("hserr_clr", sync_err, 0);

    fs0 = fs_cnt;
    fd0 = fd_cnt;
    frame(1'b1, -1, -1, 6);
    drain("vserr_strobes");
    chk("vserr_fs", fs_cnt - fs0, 2);
    chk("vserr_fd", fd_cnt - fd0, 0);
    chk("vserr_err", sync_err, 1);
    frame(1'b0, -1, -1, -1);
    drain("vserr_next_strobes");
    chk("vserr_next_fd", fd_cnt - fd0, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    chk("vserr_clr", sync_err, 0);

    do_reset();
    fs0 = fs_cnt;
    run(300, 1'b0);
    run(1100, 1'b1);
    chk("tmo_fs", fs_cnt - fs0, 1);
    chk("tmo_err", sync_err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
